// File: rtl/mem_sequencer.sv
// mem_sequencer: valid/ready front end sequencing MAR/MDR/RAM/stack strobes for the SAP-2 memory block.
// Define MEM_SEQ_WORD_WRITE_EN to enable op 5 (WR_W, big-endian word write); otherwise op 5 is illegal.
module mem_sequencer #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       bus_out,
  output logic              bus_drive,
  output logic              mar_loadh,
  output logic              mar_loadl,
  output logic              mdr_load,
  output logic              ram_load,
  output logic              ram_enh,
  output logic              ram_enl,
  output logic              call,
  output logic              ret,
  input  logic [15:0]       mem_out
);

  typedef enum logic [2:0] {
    OP_RD_B = 3'd0, OP_RD_W = 3'd1, OP_WR_B = 3'd2,
    OP_PUSH = 3'd3, OP_POP  = 3'd4, OP_WR_W = 3'd5
  } op_t;

  typedef enum logic [3:0] {
    S_IDLE, S_LDMAR, S_RDH, S_LDMAR2, S_RDL, S_LDMDR, S_WR, S_CALL, S_RET, S_ERR, S_DONE
  } state_t;

  state_t            state, nxt;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q, cur_addr, addr1;
  logic [15:0]       wdata_q, cur_wdata, bus_nxt;
  logic [7:0]        mdr_byte;
`ifdef MEM_SEQ_WORD_WRITE_EN
  logic              second_q, second_nxt;
`endif

  // Outputs are registered from the next state, so the entry cycle out of IDLE
  // must take address/data straight from the request inputs.
  always_comb begin
    cur_addr  = (state == S_IDLE) ? req_addr  : addr_q;
    cur_wdata = (state == S_IDLE) ? req_wdata : wdata_q;
    addr1     = addr_q + 1'b1;
    nxt       = state;
`ifdef MEM_SEQ_WORD_WRITE_EN
    second_nxt = second_q;
`endif
    case (state)
      S_IDLE: if (req_valid) begin
`ifdef MEM_SEQ_WORD_WRITE_EN
        second_nxt = 1'b0;
`endif
        case (req_op)
          OP_RD_B, OP_RD_W, OP_WR_B: nxt = S_LDMAR;
          OP_PUSH:                   nxt = S_CALL;
          OP_POP:                    nxt = S_RET;
`ifdef MEM_SEQ_WORD_WRITE_EN
          OP_WR_W:                   nxt = S_LDMAR;
`endif
          default:                   nxt = S_ERR;
        endcase
      end
      S_LDMAR:  nxt = (op_q == OP_RD_B) ? S_RDL : (op_q == OP_RD_W) ? S_RDH : S_LDMDR;
      S_RDH:    nxt = S_LDMAR2;
      S_LDMAR2: nxt = (op_q == OP_RD_W) ? S_RDL : S_LDMDR;
      S_RDL:    nxt = S_DONE;
      S_LDMDR:  nxt = S_WR;
`ifdef MEM_SEQ_WORD_WRITE_EN
      S_WR: begin
        if (op_q == OP_WR_W && !second_q) begin
          nxt        = S_LDMAR2;
          second_nxt = 1'b1;
        end else begin
          nxt = S_DONE;
        end
      end
`else
      S_WR:     nxt = S_DONE;
`endif
      S_CALL, S_RET, S_ERR: nxt = S_DONE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase

`ifdef MEM_SEQ_WORD_WRITE_EN
    mdr_byte = (op_q == OP_WR_W && !second_q) ? cur_wdata[15:8] : cur_wdata[7:0];
`else
    mdr_byte = cur_wdata[7:0];
`endif

    bus_nxt = '0;
    case (nxt)
      S_LDMAR:  bus_nxt = 16'(cur_addr);
      S_LDMAR2: bus_nxt = 16'(addr1);
      S_LDMDR:  bus_nxt = {8'h00, mdr_byte};
      S_CALL:   bus_nxt = cur_wdata;
      default:  bus_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      bus_out   <= '0;
      bus_drive <= 1'b0;
      mar_loadh <= 1'b0;
      mar_loadl <= 1'b0;
      mdr_load  <= 1'b0;
      ram_load  <= 1'b0;
      ram_enh   <= 1'b0;
      ram_enl   <= 1'b0;
      call      <= 1'b0;
      ret       <= 1'b0;
`ifdef MEM_SEQ_WORD_WRITE_EN
      second_q  <= 1'b0;
`endif
    end else begin
      state <= nxt;
`ifdef MEM_SEQ_WORD_WRITE_EN
      second_q <= second_nxt;
`endif
      if (state == S_IDLE && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      req_ready <= (nxt == S_IDLE);
      rsp_valid <= (nxt == S_DONE);
      rsp_err   <= (state == S_ERR);
      bus_out   <= bus_nxt;
      bus_drive <= (nxt inside {S_LDMAR, S_LDMAR2, S_LDMDR, S_CALL});
      mar_loadh <= (nxt inside {S_LDMAR, S_LDMAR2});
      mar_loadl <= (nxt inside {S_LDMAR, S_LDMAR2});
      mdr_load  <= (nxt == S_LDMDR);
      ram_load  <= (nxt == S_WR);
      ram_enh   <= (nxt == S_RDH);
      ram_enl   <= (nxt == S_RDL);
      call      <= (nxt == S_CALL);
      ret       <= (nxt == S_RET);
    end
  end

  // MDR is updated by the edge ending RDL/RET, so read data is taken live during DONE.
  always_comb begin
    rsp_rdata = '0;
    if (rsp_valid) begin
      case (op_q)
        OP_RD_B:         rsp_rdata = {8'h00, mem_out[7:0]};
        OP_RD_W, OP_POP: rsp_rdata = mem_out;
        default:         rsp_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer with a behavioural SAP-2 memory block and a response scoreboard.
module tb_mem_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata, bus_out, mem_out;
  logic        bus_drive, mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl, call, ret;

  mem_sequencer #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .bus_out(bus_out), .bus_drive(bus_drive), .mar_loadh(mar_loadh),
    .mar_loadl(mar_loadl), .mdr_load(mdr_load), .ram_load(ram_load), .ram_enh(ram_enh),
    .ram_enl(ram_enl), .call(call), .ret(ret), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [0:65535];
  logic [15:0] mar = '0, mdr = '0;
  logic [15:0] stk [$];
  assign mem_out = mdr;

  always @(posedge clk) begin
    if (mar_loadh) mar[15:8] <= bus_out[15:8];
    if (mar_loadl) mar[7:0]  <= bus_out[7:0];
    if (mdr_load)  mdr       <= bus_out;
    if (ram_load)  ram[mar]  <= mdr[7:0];
    if (ram_enh)   mdr[15:8] <= ram[mar];
    if (ram_enl)   mdr[7:0]  <= ram[mar];
    if (call)      stk.push_back(bus_out);
    if (ret && stk.size() > 0) mdr <= stk.pop_back();
  end

  typedef struct { int lat; logic [15:0] rd; logic er; } exp_t;
  exp_t sb [$];

  int n_cmp = 0, n_bad = 0;
  int n_call, n_ret, n_strb, n_drv, rdy_busy, viol;
  logic [15:0] bus_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample_cycle();
    int grp;
    bus_log.push_back(bus_out);
    grp = int'(mar_loadh | mar_loadl) + int'(mdr_load) + int'(ram_load) + int'(ram_enh)
        + int'(ram_enl) + int'(call) + int'(ret);
    if (grp > 1) viol++;
    if (mar_loadh !== mar_loadl) viol++;
    if (!bus_drive && bus_out !== 16'h0) viol++;
    if (call) n_call++;
    if (ret) n_ret++;
    if (grp > 0) n_strb++;
    if (bus_drive) n_drv++;
  endtask

  // Entered and left at a negedge with the sequencer idle.
  task automatic issue(input string tag, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] d, input int lat, input logic [15:0] rd, input logic er);
    exp_t e;
    int   cyc;
    bit   seen;
    e.lat = lat; e.rd = rd; e.er = er;
    sb.push_back(e);
    req_op = op; req_addr = a; req_wdata = d; req_valid = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    chk({tag, ".ready"}, req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 3'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
    n_call = 0; n_ret = 0; n_strb = 0; n_drv = 0; rdy_busy = 0; viol = 0;
    bus_log.delete();
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      sample_cycle();
      if (rsp_valid) seen = 1;
      else if (req_ready) rdy_busy++;
    end
    e = sb.pop_front();
    chk({tag, ".rsp_seen"}, seen, 1);
    chk({tag, ".latency"}, cyc, e.lat);
    chk({tag, ".rdata"}, rsp_rdata, e.rd);
    chk({tag, ".err"}, rsp_err, e.er);
    chk({tag, ".ready_busy"}, rdy_busy, 0);
    chk({tag, ".strobe_rules"}, viol, 0);
    @(negedge clk);
    chk({tag, ".pulse_one"}, rsp_valid, 0);
  endtask

  initial begin
    exp_t e;
    int   cyc, nresp, cnt;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    rst = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset.ready", req_ready, 1);
    chk("reset.rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("reset.bus", {bus_drive, bus_out}, 0);
    chk("reset.strobes", {mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl, call, ret}, 0);
    rst = 1'b1;
    @(negedge clk);

    issue("wr_b", 3'd2, 16'h0010, 16'h00A5, 4, 16'h0000, 1'b0);
    chk("wr_b.ram", ram[16'h0010], 8'hA5);
    issue("rd_b", 3'd0, 16'h0010, 16'h1234, 3, 16'h00A5, 1'b0);

    ram[16'h0020] = 8'h12; ram[16'h0021] = 8'h34;
    issue("rd_w", 3'd1, 16'h0020, 16'h0000, 5, 16'h1234, 1'b0);
    chk("rd_w.bus_ldmar", bus_log[0], 16'h0020);
    chk("rd_w.bus_ldmar2", bus_log[2], 16'h0021);

    issue("push", 3'd3, 16'h5555, 16'hBEEF, 2, 16'h0000, 1'b0);
    chk("push.call_cycles", n_call, 1);
    chk("push.bus", bus_log[0], 16'hBEEF);
    issue("pop", 3'd4, 16'h5555, 16'h0000, 2, 16'hBEEF, 1'b0);
    chk("pop.ret_cycles", n_ret, 1);
    chk("pop.no_drive", n_drv, 0);

    issue("op7", 3'd7, 16'h0040, 16'h0000, 2, 16'h0000, 1'b1);
    chk("op7.no_strobe", n_strb + n_drv, 0);
    issue("op6", 3'd6, 16'h0040, 16'h0000, 2, 16'h0000, 1'b1);
    chk("op6.no_strobe", n_strb + n_drv, 0);
`ifdef MEM_SEQ_WORD_WRITE_EN
    issue("wr_w", 3'd5, 16'hFFFF, 16'hCAFE, 7, 16'h0000, 1'b0);
    chk("wr_w.ram_hi", ram[16'hFFFF], 8'hCA);
    chk("wr_w.ram_lo", ram[16'h0000], 8'hFE);
    chk("wr_w.bus_wrap", bus_log[3], 16'h0000);
`else
    issue("op5", 3'd5, 16'hFFFF, 16'hCAFE, 2, 16'h0000, 1'b1);
    chk("op5.no_strobe", n_strb + n_drv, 0);
    chk("op5.ram_untouched", ram[16'hFFFF], 8'h00);
`endif

    // Back-to-back: req_valid held through the first sequence.
    e.lat = 3; e.rd = 16'h00A5; e.er = 1'b0; sb.push_back(e);
    e.lat = 7; e.rd = 16'h0012; e.er = 1'b0; sb.push_back(e);
    req_valid = 1'b1; req_op = 3'd0; req_addr = 16'h0010;
    chk("b2b.ready0", req_ready, 1);
    @(posedge clk); #1;
    req_addr = 16'h0020;
    cyc = 0; nresp = 0; rdy_busy = 0;
    for (int i = 0; i < 16 && nresp < 2; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc <= 3 && req_ready) rdy_busy++;
      if (rsp_valid) begin
        e = sb.pop_front();
        chk("b2b.latency", cyc, e.lat);
        chk("b2b.rdata", rsp_rdata, e.rd);
        nresp++;
      end
      if (cyc == 4) begin
        chk("b2b.ready_gap", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("b2b.responses", nresp, 2);
    chk("b2b.ready_busy", rdy_busy, 0);
    @(negedge clk);

    // Reset abandons an RD_W in its RDH cycle.
    req_valid = 1'b1; req_op = 3'd1; req_addr = 16'h0020;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort.in_rdh", ram_enh, 1);
    rst = 1'b0;
    #1;
    chk("abort.strobes", {mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl, call, ret}, 0);
    chk("abort.ready", req_ready, 1);
    chk("abort.bus", {bus_drive, bus_out}, 0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("abort.no_rsp", cnt, 0);
    issue("post_abort", 3'd0, 16'h0021, 16'h0000, 3, 16'h0034, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_sequencer.md
Name: mem_sequencer

Overview:
- Initiator side of the SAP-2 memory block's control interface.
- Accepts byte, word and stack requests on a valid/ready interface. Sequences the MAR/MDR/RAM strobes over multiple cycles, then returns read data on a one-cycle response pulse.
- Sits between the control unit or a program loader and the memory block. It drives the shared 16-bit bus only while it owns it.

Parameters:
- ADDR_W, 16, address width; full width goes to the MAR, and the memory truncates internally.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle and able to accept a request
- req_op  in  3  0=RD_B, 1=RD_W, 2=WR_B, 3=PUSH, 4=POP, 5=WR_W (optional), 6-7 illegal
- req_addr  in  ADDR_W  byte address; ignored for PUSH/POP
- req_wdata  in  16  write data; WR_B uses [7:0], PUSH/WR_W use [15:0]
- rsp_valid  out  1  one-cycle completion pulse, issued for every accepted request
- rsp_rdata  out  16  read result, valid while rsp_valid is high
- rsp_err  out  1  illegal op, valid while rsp_valid is high
- bus_out  out  16  value the sequencer drives onto the bus
- bus_drive  out  1  bus_out is valid; bus arbiter enable
- mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl, call, ret  out  1 each  memory strobes
- mem_out  in  16  memory block MDR output

Behaviour:
- Reset (rst low, async):
  - State goes to IDLE immediately.
  - All strobes, bus_drive, rsp_valid and rsp_err are 0; bus_out and rsp_rdata are 0; req_ready is 1.
  - Reset mid-operation abandons the sequence. Partially written RAM is acceptable.
- Handshake:
  - req_ready = (state==IDLE).
  - A request is accepted on a rising edge with req_valid & req_ready. op/addr/wdata are latched at that edge; inputs are don't-care afterwards.
- Strobe timing rules:
  - Memory samples strobes at the edge that ends the cycle.
  - ram_enh/ram_enl/ram_load use the MAR value from before that edge, so a MAR load and the RAM access that uses it are never in the same cycle.
- States after acceptance; each state lasts exactly 1 cycle:
  - RD_B: LDMAR (bus=addr, mar_loadh=mar_loadl=1) -> RDL (ram_enl) -> DONE.
  - RD_W (big-endian): LDMAR (addr) -> RDH (ram_enh) -> LDMAR2 (bus=addr+1, mod 2^16; FFFF wraps to 0000) -> RDL -> DONE.
  - WR_B: LDMAR -> LDMDR (bus={8'h00,wdata[7:0]}, mdr_load) -> WR (ram_load) -> DONE.
  - PUSH: CALL (bus=wdata, call) -> DONE.
  - POP: RET (ret) -> DONE.
  - Illegal op: ERR (no strobes) -> DONE with rsp_err=1.
- bus_drive is 1 only in LDMAR, LDMAR2, LDMDR and CALL. bus_out is 0 whenever bus_drive=0.
- At most one strobe group is active per cycle. call/ret are never asserted together with ram_*.
- DONE:
  - rsp_valid=1.
  - rsp_rdata: RD_B={8'h00,mem_out[7:0]}; RD_W/POP=mem_out; all others 0.
  - Next state is IDLE. A new request can be accepted in the cycle after DONE, giving a throughput gap of 1 IDLE cycle.
- Latency from the acceptance edge to the rsp_valid cycle:
  - RD_B 3 cycles.
  - RD_W 5 cycles.
  - WR_B 4 cycles.
  - WR_W 7 cycles.
  - PUSH, POP and illegal ops: 2 cycles each.
- req_valid while busy is ignored; the requester holds it until req_ready.

Optional Feature:
- Macro: MEM_SEQ_WORD_WRITE_EN.
- Defined: op 5 (WR_W) sequences LDMAR(addr) -> LDMDR(bus={8'h00,wdata[15:8]}) -> WR -> LDMAR2(addr+1) -> LDMDR(bus={8'h00,wdata[7:0]}) -> WR -> DONE. This writes the high byte at addr and the low byte at addr+1, with wrap as above.
- Undefined: op 5 is illegal and takes the ERR path with rsp_err=1 and no strobes. The states and logic for WR_W are not synthesized.

Test Plan:
- Reset: hold rst low mid-RD_W (in RDH), release -> all strobes 0 immediately, req_ready=1, rsp_valid never pulses for the aborted request.
- WR_B addr=0x0010 wdata=0x00A5, then RD_B addr=0x0010:
  - Write -> rsp_valid 4 cycles after acceptance.
  - Read -> rsp_valid 3 cycles after acceptance, rsp_rdata=0x00A5.
- Preload RAM[0x20]=0x12, RAM[0x21]=0x34; RD_W addr=0x0020 -> rsp_rdata=0x1234 at 5-cycle latency; the LDMAR2 cycle shows bus_out=0x0021.
- PUSH wdata=0xBEEF then POP:
  - Each completes in 2 cycles.
  - POP rsp_rdata=0xBEEF.
  - call/ret each high exactly 1 cycle.
  - bus_drive=0 during RET.
- req_op=7 -> rsp_valid with rsp_err=1 after 2 cycles, no strobe asserted. Repeat with op=5:
  - Macro undefined: rsp_err=1.
  - Macro defined: WR_W addr=0xFFFF wdata=0xCAFE stores 0xCA at 0xFFFF and 0xFE at 0x0000.
- Back-to-back: req_valid held high with two RD_B -> second accepted the cycle after the first DONE; req_ready=0 throughout the first sequence.
